// File: rtl/prt_phy_drp_rmw_if.sv
// ----------------------------------------------------------------------------
// prt_phy_drp_rmw_if
// Local-bus link between the DRP read-modify-write engine and the PHY
// controller register block. Signal names are seen from the bus master.
//   LB_ADR_OUT  register address (0 CTL, 1 STA, 2 DRP)
//   LB_WR_OUT   single-clock write strobe
//   LB_RD_OUT   single-clock read strobe
//   LB_DAT_OUT  write data
//   LB_DAT_IN   read data, qualified by LB_VLD_IN
//   LB_VLD_IN   read data valid
// ----------------------------------------------------------------------------
interface prt_phy_drp_rmw_if;
    logic [3:0]  LB_ADR_OUT;
    logic        LB_WR_OUT;
    logic        LB_RD_OUT;
    logic [31:0] LB_DAT_OUT;
    logic [31:0] LB_DAT_IN;
    logic        LB_VLD_IN;

    modport master (
        output LB_ADR_OUT, LB_WR_OUT, LB_RD_OUT, LB_DAT_OUT,
        input  LB_DAT_IN, LB_VLD_IN
    );

    modport slave (
        input  LB_ADR_OUT, LB_WR_OUT, LB_RD_OUT, LB_DAT_OUT,
        output LB_DAT_IN, LB_VLD_IN
    );
endinterface

// File: rtl/prt_phy_drp_rmw.sv
// ----------------------------------------------------------------------------
// prt_phy_drp_rmw
// Performs one DRP read (and optionally a masked write-back) through the PHY
// controller's local-bus register map. A request latches port/address/mask/
// data; the engine reads the DRP word, reports it on DAT_OUT and, when the
// mask is non-zero, writes back (rd & ~MSK) | (DAT & MSK).
// Ports:
//   SYS_CLK_IN, SYS_RST_IN  clock, asynchronous active-high reset
//   REQ_IN, PORT_IN, ADR_IN, MSK_IN, DAT_IN   request (taken when RDY_OUT=1)
//   RDY_OUT   idle, DONE_OUT one-clock completion, ERR_OUT timeout flag
//   DAT_OUT   DRP value read before modification
//   lb        local-bus master towards the PHY controller
// ----------------------------------------------------------------------------
module prt_phy_drp_rmw #(
    parameter int P_DRP_PORT_WIDTH = 3,
    parameter int P_DRP_ADR        = 10,
    parameter int P_DRP_DAT        = 16,
    parameter int P_TIMEOUT        = 1024
) (
    input  logic                        SYS_CLK_IN,
    input  logic                        SYS_RST_IN,
    input  logic                        REQ_IN,
    input  logic [P_DRP_PORT_WIDTH-1:0] PORT_IN,
    input  logic [P_DRP_ADR-1:0]        ADR_IN,
    input  logic [P_DRP_DAT-1:0]        MSK_IN,
    input  logic [P_DRP_DAT-1:0]        DAT_IN,
    output logic                        RDY_OUT,
    output logic                        DONE_OUT,
    output logic                        ERR_OUT,
    output logic [P_DRP_DAT-1:0]        DAT_OUT,
    prt_phy_drp_rmw_if.master           lb
);
    localparam int TMO_W = $clog2(P_TIMEOUT) + 1;

    localparam logic [3:0]  REG_CTL = 4'd0;
    localparam logic [3:0]  REG_STA = 4'd1;
    localparam logic [3:0]  REG_DRP = 4'd2;
    localparam logic [31:0] CTL_WR  = 32'h1;
    localparam logic [31:0] CTL_RD  = 32'h2;

    typedef enum logic [3:0] {
        ST_IDLE, ST_SET_ADR, ST_CMD_RD, ST_POLL_RDY, ST_GET_DAT,
        ST_SET_WDAT, ST_CMD_WR, ST_POLL_HI, ST_POLL_LO, ST_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic                        pend_q, pend_d;   // one LB read outstanding
    logic [TMO_W-1:0]            tmo_q, tmo_d;
    logic                        err_q, err_d;
    logic [P_DRP_DAT-1:0]        dat_q, dat_d;

    logic [P_DRP_PORT_WIDTH-1:0] port_q;
    logic [P_DRP_ADR-1:0]        adr_q;
    logic [P_DRP_DAT-1:0]        msk_q, wdat_q;

    logic                        acc;
    logic                        lb_wr, lb_rd;
    logic [3:0]                  lb_adr, wait_adr;
    logic [31:0]                 lb_wdat;
    logic                        wait_met, tmo_hit;
    state_t                      wait_next;
    logic                        unused_lb_dat;

    // DRP register layout: {dat, adr, port} with port at the LSB, zero padded.
    function automatic logic [31:0] drp_word(input logic [P_DRP_DAT-1:0] d);
        drp_word = 32'({d, adr_q, port_q});
    endfunction

    function automatic logic [P_DRP_DAT-1:0] merge(input logic [P_DRP_DAT-1:0] rd,
                                                   input logic [P_DRP_DAT-1:0] m,
                                                   input logic [P_DRP_DAT-1:0] d);
        merge = (rd & ~m) | (d & m);
    endfunction

    assign tmo_hit       = (tmo_q == TMO_W'(P_TIMEOUT - 1));
    assign unused_lb_dat = ^lb.LB_DAT_IN;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        dat_d     = dat_q;
        acc       = 1'b0;
        lb_wr     = 1'b0;
        lb_rd     = 1'b0;
        lb_adr    = 4'd0;
        lb_wdat   = 32'd0;
        wait_adr  = REG_STA;
        wait_met  = 1'b0;
        wait_next = ST_DONE;

        // Exit condition and successor of each polling/read state.
        case (state_q)
            ST_POLL_RDY: begin
                wait_met  = lb.LB_DAT_IN[1];
                wait_next = ST_GET_DAT;
            end
            ST_GET_DAT: begin
                wait_adr  = REG_DRP;
                wait_met  = 1'b1;
                wait_next = (msk_q == '0) ? ST_DONE : ST_SET_WDAT;
            end
            ST_POLL_HI: begin
                wait_met  = lb.LB_DAT_IN[0];
                wait_next = ST_POLL_LO;
            end
            ST_POLL_LO: begin
                wait_met  = ~lb.LB_DAT_IN[0];
                wait_next = ST_DONE;
            end
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (REQ_IN) begin
                    acc     = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_SET_ADR;
                end
            end
            ST_SET_ADR: begin
                lb_wr   = 1'b1;
                lb_adr  = REG_DRP;
                lb_wdat = drp_word('0);
                state_d = ST_CMD_RD;
            end
            ST_CMD_RD: begin
                lb_wr   = 1'b1;
                lb_adr  = REG_CTL;
                lb_wdat = CTL_RD;
                tmo_d   = '0;
                pend_d  = 1'b0;
                state_d = ST_POLL_RDY;
            end
            ST_POLL_RDY, ST_GET_DAT, ST_POLL_HI, ST_POLL_LO: begin
                tmo_d = tmo_q + 1'b1;
                if (pend_q && lb.LB_VLD_IN && wait_met) begin
                    pend_d  = 1'b0;
                    tmo_d   = '0;
                    state_d = wait_next;
                    if (state_q == ST_GET_DAT) begin
                        dat_d = lb.LB_DAT_IN[P_DRP_DAT-1:0];
                    end
                end else if (tmo_hit) begin
                    // Abandon without issuing another strobe.
                    pend_d  = 1'b0;
                    tmo_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (!pend_q) begin
                    lb_rd  = 1'b1;
                    lb_adr = wait_adr;
                    pend_d = 1'b1;
                end else if (lb.LB_VLD_IN) begin
                    // Condition not met: re-issue on the following clock.
                    pend_d = 1'b0;
                end
            end
            ST_SET_WDAT: begin
                lb_wr   = 1'b1;
                lb_adr  = REG_DRP;
                lb_wdat = drp_word(merge(dat_q, msk_q, wdat_q));
                state_d = ST_CMD_WR;
            end
            ST_CMD_WR: begin
                lb_wr   = 1'b1;
                lb_adr  = REG_CTL;
                lb_wdat = CTL_WR;
                tmo_d   = '0;
                pend_d  = 1'b0;
                state_d = ST_POLL_HI;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK_IN or posedge SYS_RST_IN) begin
        if (SYS_RST_IN) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // Request fields are pure data: captured once at acceptance.
    always_ff @(posedge SYS_CLK_IN) begin
        if (acc) begin
            port_q <= PORT_IN;
            adr_q  <= ADR_IN;
            msk_q  <= MSK_IN;
            wdat_q <= DAT_IN;
        end
    end

    assign RDY_OUT       = (state_q == ST_IDLE);
    assign DONE_OUT      = (state_q == ST_DONE);
    assign ERR_OUT       = err_q;
    assign DAT_OUT       = dat_q;
    assign lb.LB_WR_OUT  = lb_wr;
    assign lb.LB_RD_OUT  = lb_rd;
    assign lb.LB_ADR_OUT = lb_adr;
    assign lb.LB_DAT_OUT = lb_wdat;
endmodule

// File: tb/tb_prt_phy_drp_rmw.sv
module tb_prt_phy_drp_rmw;
    localparam int PW     = 3;
    localparam int AW     = 10;
    localparam int DW     = 16;
    localparam int TMO    = 32;
    localparam int BUDGET = 4 * TMO + 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [PW-1:0] port;
    logic [AW-1:0] adr;
    logic [DW-1:0] msk, dat;
    logic          rdy, done, err;
    logic [DW-1:0] dout;

    always #5 clk = ~clk;

    prt_phy_drp_rmw_if lb();

    prt_phy_drp_rmw #(
        .P_DRP_PORT_WIDTH(PW), .P_DRP_ADR(AW), .P_DRP_DAT(DW), .P_TIMEOUT(TMO)
    ) dut (
        .SYS_CLK_IN(clk), .SYS_RST_IN(rst), .REQ_IN(req), .PORT_IN(port),
        .ADR_IN(adr), .MSK_IN(msk), .DAT_IN(dat), .RDY_OUT(rdy),
        .DONE_OUT(done), .ERR_OUT(err), .DAT_OUT(dout), .lb(lb.slave)
    );

    int errors = 0;
    int checks = 0;

    // PHY controller model: read data returned two clocks after the strobe.
    logic [15:0] drp_rd_val = 16'h0;
    logic        never_rdy  = 1'b0;
    logic        v1, v2, busy_arm, outst, prev_wr, prev_rd;
    logic [31:0] d1, d2;
    logic [3:0]  prev_adr;
    int          rdy_cnt, busy_cnt;
    int          n_ctl1 = 0, n_ctl2 = 0, n_drp_wr = 0, n_strobe = 0, proto_err = 0;
    logic [31:0] last_drp_w = 32'h0, prev_drp_w = 32'h0;

    assign lb.LB_VLD_IN = v2;
    assign lb.LB_DAT_IN = v2 ? d2 : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0; v2 <= 1'b0; d1 <= 32'h0; d2 <= 32'h0;
            rdy_cnt <= 0; busy_cnt <= 0; busy_arm <= 1'b0;
            outst <= 1'b0; prev_wr <= 1'b0; prev_rd <= 1'b0; prev_adr <= 4'h0;
        end else begin
            v2 <= v1;
            d2 <= d1;
            v1 <= lb.LB_RD_OUT;
            d1 <= 32'h0;
            if (lb.LB_RD_OUT) begin
                if (lb.LB_ADR_OUT == 4'd1) begin
                    d1 <= {30'd0, (!never_rdy && rdy_cnt == 0),
                           (busy_arm && (busy_cnt == 1 || busy_cnt == 2))};
                    if (rdy_cnt > 0) rdy_cnt <= rdy_cnt - 1;
                    if (busy_arm) busy_cnt <= busy_cnt + 1;
                end else if (lb.LB_ADR_OUT == 4'd2) begin
                    d1 <= {16'h0, drp_rd_val};
                end
            end
            if (lb.LB_WR_OUT && lb.LB_ADR_OUT == 4'd0 && lb.LB_DAT_OUT == 32'h2) begin
                rdy_cnt  <= 2;
                busy_arm <= 1'b0;
                n_ctl2   <= n_ctl2 + 1;
            end
            if (lb.LB_WR_OUT && lb.LB_ADR_OUT == 4'd0 && lb.LB_DAT_OUT == 32'h1) begin
                busy_arm <= 1'b1;
                busy_cnt <= 0;
                n_ctl1   <= n_ctl1 + 1;
            end
            if (lb.LB_WR_OUT && lb.LB_ADR_OUT == 4'd2) begin
                n_drp_wr   <= n_drp_wr + 1;
                prev_drp_w <= last_drp_w;
                last_drp_w <= lb.LB_DAT_OUT;
            end
            if (lb.LB_WR_OUT || lb.LB_RD_OUT) n_strobe <= n_strobe + 1;
            // Protocol monitor
            prev_wr  <= lb.LB_WR_OUT;
            prev_rd  <= lb.LB_RD_OUT;
            prev_adr <= lb.LB_ADR_OUT;
            if ((lb.LB_WR_OUT && prev_wr && lb.LB_ADR_OUT == prev_adr) ||
                (lb.LB_RD_OUT && prev_rd) || (lb.LB_RD_OUT && outst) ||
                (lb.LB_WR_OUT && lb.LB_RD_OUT) ||
                (!lb.LB_WR_OUT && !lb.LB_RD_OUT &&
                 (lb.LB_ADR_OUT != 4'h0 || lb.LB_DAT_OUT != 32'h0)))
                proto_err <= proto_err + 1;
            if (lb.LB_RD_OUT) outst <= 1'b1;
            else if (v2) outst <= 1'b0;
        end
    end

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; port = '0; adr = '0; msk = '0; dat = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rdy, done, err, lb.LB_WR_OUT, lb.LB_RD_OUT} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 10000", {rdy, done, err, lb.LB_WR_OUT, lb.LB_RD_OUT});
        end
        checks++;
        if ({dout, lb.LB_ADR_OUT, lb.LB_DAT_OUT} !== 52'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h expected 0", dout, lb.LB_ADR_OUT, lb.LB_DAT_OUT);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy, done, err} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: got %b expected 100", {rdy, done, err});
        end
    endtask

    task automatic run_req(input logic [PW-1:0] p, input logic [AW-1:0] a,
                           input logic [DW-1:0] m, input logic [DW-1:0] d,
                           output bit got, output int cyc);
        req = 1'b1; port = p; adr = a; msk = m; dat = d;
        @(negedge clk);
        // Scramble inputs: the latched request must be used.
        req = 1'b0; port = ~p; adr = ~a; msk = ~m; dat = ~d;
        got = 1'b0; cyc = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (done) begin got = 1'b1; break; end
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_wait: no DONE_OUT within %0d clocks", BUDGET);
        end
    endtask

    task automatic test_rmw();
        int c1, c2, w, cyc; bit got;
        drp_rd_val = 16'h1234; never_rdy = 1'b0;
        c1 = n_ctl1; c2 = n_ctl2; w = n_drp_wr;
        run_req(3'd2, 10'h005, 16'h00FF, 16'h00AB, got, cyc);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rmw_err: got %b expected 0", err); end
        checks++;
        if (dout !== 16'h1234) begin errors++; $display("FAIL rmw_dat_out: got %h expected 1234", dout); end
        checks++;
        if (prev_drp_w !== 32'h0000002A) begin errors++; $display("FAIL rmw_adr_wr: got %h expected 0000002a", prev_drp_w); end
        checks++;
        if (last_drp_w !== 32'h0255602A) begin errors++; $display("FAIL rmw_data_wr: got %h expected 0255602a", last_drp_w); end
        checks++;
        if ({n_ctl1 - c1, n_ctl2 - c2, n_drp_wr - w} !== {32'd1, 32'd1, 32'd2}) begin
            errors++;
            $display("FAIL rmw_writes: ctl1=%0d ctl2=%0d drp=%0d expected 1 1 2", n_ctl1 - c1, n_ctl2 - c2, n_drp_wr - w);
        end
        @(negedge clk);
        checks++;
        if ({done, rdy} !== 2'b01) begin errors++; $display("FAIL rmw_done_width: got %b expected 01", {done, rdy}); end
    endtask

    task automatic test_read_only();
        int c1, w, cyc; bit got;
        drp_rd_val = 16'hBEEF; never_rdy = 1'b0;
        c1 = n_ctl1; w = n_drp_wr;
        run_req(3'd1, 10'h003, 16'h0000, 16'hFFFF, got, cyc);
        checks++;
        if ({err, dout} !== {1'b0, 16'hBEEF}) begin errors++; $display("FAIL ro_result: got %b/%h expected 0/beef", err, dout); end
        checks++;
        if ({n_ctl1 - c1, n_drp_wr - w} !== {32'd0, 32'd1}) begin
            errors++;
            $display("FAIL ro_writes: ctl1=%0d drp=%0d expected 0 1", n_ctl1 - c1, n_drp_wr - w);
        end
        checks++;
        if (last_drp_w !== 32'h00000019) begin errors++; $display("FAIL ro_adr_wr: got %h expected 00000019", last_drp_w); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int c1, c2, w, cyc; bit got;
        never_rdy = 1'b1;
        c1 = n_ctl1; c2 = n_ctl2; w = n_drp_wr;
        run_req(3'd0, 10'h001, 16'hFFFF, 16'h0000, got, cyc);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", err); end
        checks++;
        if (cyc !== TMO + 2) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", cyc, TMO + 2); end
        checks++;
        if ({n_ctl1 - c1, n_ctl2 - c2, n_drp_wr - w} !== {32'd0, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL tmo_writes: ctl1=%0d ctl2=%0d drp=%0d expected 0 1 1", n_ctl1 - c1, n_ctl2 - c2, n_drp_wr - w);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({rdy, err} !== 2'b11) begin errors++; $display("FAIL tmo_err_hold: got %b expected 11", {rdy, err}); end
        never_rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc, nd, d1_idx, a2_idx, w;
        drp_rd_val = 16'h5A5A; never_rdy = 1'b0;
        acc = 0; nd = 0; d1_idx = -10; a2_idx = -1; w = n_drp_wr;
        req = 1'b1; port = 3'd4; adr = 10'h011; msk = 16'h0; dat = 16'h0;
        for (int i = 0; i < 2 * BUDGET; i++) begin
            if (rdy && req) begin acc++; if (acc == 2) a2_idx = i; end
            if (done) begin
                nd++;
                if (nd == 1) d1_idx = i;
                checks++;
                if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_in_done: got %b expected 0", rdy); end
                if (nd == 2) break;
            end
            @(negedge clk);
        end
        req = 1'b0;
        checks++;
        if ({nd, acc} !== {32'd2, 32'd2}) begin errors++; $display("FAIL b2b_count: dones=%0d accepts=%0d expected 2 2", nd, acc); end
        checks++;
        if (a2_idx !== d1_idx + 1) begin errors++; $display("FAIL b2b_accept_slot: got %0d expected %0d", a2_idx, d1_idx + 1); end
        checks++;
        if ({err, dout} !== {1'b0, 16'h5A5A}) begin errors++; $display("FAIL b2b_result: got %b/%h expected 0/5a5a", err, dout); end
        checks++;
        if (n_drp_wr - w !== 2) begin errors++; $display("FAIL b2b_ignored_busy: drp writes %0d expected 2", n_drp_wr - w); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c1, s; bit hit;
        drp_rd_val = 16'h1234; never_rdy = 1'b0;
        c1 = n_ctl1; hit = 1'b0;
        req = 1'b1; port = 3'd2; adr = 10'h005; msk = 16'h00FF; dat = 16'h00AB;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (n_ctl1 != c1) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_reach_poll_hi: CTL=1 write never seen"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rdy, done, err, lb.LB_WR_OUT, lb.LB_RD_OUT} !== 5'b10000) begin
            errors++;
            $display("FAIL mid_reset_ctl: got %b expected 10000", {rdy, done, err, lb.LB_WR_OUT, lb.LB_RD_OUT});
        end
        checks++;
        if ({dout, lb.LB_ADR_OUT, lb.LB_DAT_OUT} !== 52'h0) begin
            errors++;
            $display("FAIL mid_reset_data: got %h/%h/%h expected 0", dout, lb.LB_ADR_OUT, lb.LB_DAT_OUT);
        end
        @(negedge clk);
        rst = 1'b0;
        s = n_strobe;
        repeat (10) @(negedge clk);
        checks++;
        if ({n_strobe - s, 32'(rdy)} !== {32'd0, 32'd1}) begin
            errors++;
            $display("FAIL mid_no_strobes: strobes=%0d rdy=%b expected 0 1", n_strobe - s, rdy);
        end
    endtask

    initial begin
        test_reset();
        test_rmw();
        test_read_only();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (proto_err !== 0) begin errors++; $display("FAIL protocol_monitor: violations=%0d expected 0", proto_err); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
